// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// controller states and register-file write codes.
package mul_div_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        OP_MULLO = 2'b00,
        OP_MULHI = 2'b01,
        OP_DIVQ  = 2'b10,
        OP_DIVR  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    typedef enum logic [1:0] {
        WRT_NONE = 2'b00,
        WRT_R31  = 2'b01,
        WRT_RS   = 2'b10,
        WRT_RT   = 2'b11
    } reg_wrt_e;

    // op[1] selects divide; op[0] selects the upper half of the shift register.
    function automatic logic op_is_div(md_op_e op);
        return op[1];
    endfunction

    function automatic logic op_takes_high(md_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the issuing pipeline and the mul/div unit.
interface mul_div_unit_if
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    md_op_e           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       reg_wrt_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [1:0]       reg_wrt_out;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, reg_wrt_in,
        input  busy, done, result, reg_wrt_out, div_by_zero
    );

    modport slave (
        input  start, op, a, b, reg_wrt_in,
        output busy, done, result, reg_wrt_out, div_by_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide: one 64-bit shift register and one 33-bit
// add/subtract shared by shift-add multiply and restoring division.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    mul_div_unit_if.slave     bus
);

    md_state_e          state_reg;
    md_op_e             op_reg;
    logic [WIDTH-1:0]   operand_reg;
    logic [1:0]         wrt_reg;
    logic [2*WIDTH-1:0] shift_reg;
    logic [2*WIDTH-1:0] shift_next;
    logic [CNT_W-1:0]   count_reg;

    logic               busy_reg;
    logic               done_reg;
    logic               dbz_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [WIDTH-1:0]   result_next;
    logic [1:0]         wrt_out_reg;

    logic               sub;
    logic [WIDTH:0]     alu_a;
    logic [WIDTH:0]     alu_b;
    logic [WIDTH:0]     alu_b_x;
    logic [WIDTH+1:0]   alu_sum;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // Multiply adds the multiplicand into the high half; divide subtracts the
    // divisor from the 33-bit partial remainder (high half shifted left by one).
    assign sub   = op_is_div(op_reg);
    assign alu_a = sub ? shift_reg[2*WIDTH-1:WIDTH-1] : {1'b0, shift_reg[2*WIDTH-1:WIDTH]};
    assign alu_b = {1'b0, operand_reg};

    generate
        for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_alu_inv
            assign alu_b_x[gi] = alu_b[gi] ^ sub;
        end
    endgenerate

    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b_x} + {{(WIDTH+1){1'b0}}, sub};

    always_comb begin
        shift_next = shift_reg;
        if (!sub) begin
            if (shift_reg[0]) begin
                shift_next = {alu_sum[WIDTH:0], shift_reg[WIDTH-1:1]};
            end else begin
                shift_next = {1'b0, shift_reg[2*WIDTH-1:1]};
            end
        end else begin
            // Carry out of the subtract means partial remainder >= divisor.
            if (alu_sum[WIDTH+1]) begin
                shift_next = {alu_sum[WIDTH-1:0], shift_reg[WIDTH-2:0], 1'b1};
            end else begin
                shift_next = {shift_reg[2*WIDTH-2:0], 1'b0};
            end
        end
    end

    assign result_next = op_takes_high(op_reg) ? shift_next[2*WIDTH-1:WIDTH]
                                               : shift_next[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            op_reg      <= OP_MULLO;
            operand_reg <= '0;
            wrt_reg     <= WRT_NONE;
            shift_reg   <= '0;
            count_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            dbz_reg     <= 1'b0;
            result_reg  <= '0;
            wrt_out_reg <= WRT_NONE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg    <= 1'b0;
                    wrt_out_reg <= WRT_NONE;
                    if (bus.start) begin
                        op_reg    <= bus.op;
                        wrt_reg   <= bus.reg_wrt_in;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        if (op_is_div(bus.op)) begin
                            operand_reg <= bus.b;
                            shift_reg   <= {{WIDTH{1'b0}}, bus.a};
                        end else begin
                            operand_reg <= bus.a;
                            shift_reg   <= {{WIDTH{1'b0}}, bus.b};
                        end
                        // Divide by zero short-circuits straight to completion.
                        if (op_is_div(bus.op) && (bus.b == '0)) begin
                            state_reg   <= ST_DONE;
                            done_reg    <= 1'b1;
                            dbz_reg     <= 1'b1;
                            result_reg  <= op_takes_high(bus.op) ? bus.a : '1;
                            wrt_out_reg <= bus.reg_wrt_in;
                        end else begin
                            state_reg <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    shift_reg <= shift_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST_ITER) begin
                        state_reg   <= ST_DONE;
                        done_reg    <= 1'b1;
                        dbz_reg     <= 1'b0;
                        result_reg  <= result_next;
                        wrt_out_reg <= wrt_reg;
                    end
                end
                ST_DONE: begin
                    state_reg   <= ST_IDLE;
                    done_reg    <= 1'b0;
                    busy_reg    <= 1'b0;
                    wrt_out_reg <= WRT_NONE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.result      = result_reg;
    assign bus.reg_wrt_out = wrt_out_reg;
    assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected results are queued at issue and
// compared when done pulses, along with latency and write-code behaviour.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dbz;
        logic [1:0]  wrt;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(32)) bus ();
    mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_res = '0;
    logic        last_dbz = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(md_op_e op, logic [31:0] a, logic [31:0] b, logic [1:0] wrt, int acc);
        exp_t        e;
        logic [63:0] p;
        p     = {32'b0, a} * {32'b0, b};
        e.op  = op;
        e.a   = a;
        e.b   = b;
        e.wrt = wrt;
        e.acc = acc;
        e.dbz = (op == OP_DIVQ || op == OP_DIVR) && (b == 32'd0);
        e.lat = e.dbz ? 1 : 33;
        case (op)
            OP_MULLO: e.res = p[31:0];
            OP_MULHI: e.res = p[63:32];
            OP_DIVQ:  e.res = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default:  e.res = (b == 32'd0) ? a : a % b;
        endcase
        return e;
    endfunction

    // Monitor: one line per completed transaction.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (bus.done) begin
                n_done++;
                if (sb.size() == 0) begin
                    check_val("spurious_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("result", bus.result, e.res);
                    check_val("div_by_zero", bus.div_by_zero, e.dbz);
                    check_val("reg_wrt_out", bus.reg_wrt_out, e.wrt);
                    check_val("latency", cyc - e.acc, e.lat);
                    check_val("busy_in_done", bus.busy, 1);
                    last_res = e.res;
                    last_dbz = e.dbz;
                    $display("op=%s a=%h b=%h result=%h dbz=%0d wrt=%0d lat=%0d",
                             e.op.name(), e.a, e.b, bus.result, bus.div_by_zero,
                             bus.reg_wrt_out, cyc - e.acc);
                end
            end else begin
                check_val("wrt_quiet", bus.reg_wrt_out, 2'b00);
            end
        end
    end

    // Called at a negedge; leaves start low just after the acceptance edge.
    task automatic start_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] wrt);
        bus.op         = op;
        bus.a          = a;
        bus.b          = b;
        bus.reg_wrt_in = wrt;
        bus.start      = 1'b1;
        sb.push_back(model(op, a, b, wrt, cyc));
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Returns at the negedge of the first IDLE cycle after completion.
    task automatic wait_idle();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check_val("timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
        check_val("busy_after", bus.busy, 0);
        check_val("result_hold", bus.result, last_res);
        check_val("dbz_hold", bus.div_by_zero, last_dbz);
    endtask

    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] wrt);
        start_op(op, a, b, wrt);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, bus.busy, 0);
        check_val({tag, "_done"}, bus.done, 0);
        check_val({tag, "_result"}, bus.result, 0);
        check_val({tag, "_wrt"}, bus.reg_wrt_out, 0);
        check_val({tag, "_dbz"}, bus.div_by_zero, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        md_op_e      rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.op         = OP_MULLO;
        bus.a          = '0;
        bus.b          = '0;
        bus.reg_wrt_in = 2'b00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst    = 1'b0;
        mon_en = 1'b1;

        run_op(OP_MULLO, 32'd7, 32'd6, 2'b11);
        run_op(OP_MULHI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01);
        run_op(OP_MULLO, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10);
        run_op(OP_DIVQ, 32'd100, 32'd7, 2'b11);
        run_op(OP_DIVR, 32'd100, 32'd7, 2'b10);
        run_op(OP_DIVQ, 32'd5, 32'd0, 2'b01);
        run_op(OP_DIVR, 32'd5, 32'd0, 2'b11);
        run_op(OP_DIVQ, 32'd1, 32'd3, 2'b10);
        run_op(OP_DIVR, 32'd1, 32'd3, 2'b01);
        run_op(OP_MULLO, 32'd0, 32'h1234_5678, 2'b11);
        run_op(OP_MULHI, 32'h8000_0001, 32'd0, 2'b10);

        for (int i = 0; i < 10; i++) begin
            rop = md_op_e'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, 2'($urandom_range(1, 3)));
        end

        // A start while busy must be ignored entirely.
        d0 = n_done;
        start_op(OP_DIVR, 32'd1000, 32'd33, 2'b10);
        repeat (10) @(negedge clk);
        check_val("busy_mid", bus.busy, 1);
        bus.op         = OP_MULLO;
        bus.a          = 32'd9;
        bus.b          = 32'd9;
        bus.reg_wrt_in = 2'b01;
        bus.start      = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        check_val("one_done", n_done - d0, 1);

        // Reset in the middle of a divide discards it.
        run_op(OP_DIVQ, 32'd9, 32'd0, 2'b11);
        start_op(OP_DIVQ, 32'hDEAD_BEEF, 32'd3, 2'b10);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check_reset_outputs("midreset");
        rst      = 1'b0;
        last_res = '0;
        last_dbz = 1'b0;
        repeat (40) @(negedge clk);
        run_op(OP_MULLO, 32'd3, 32'd3, 2'b01);

        check_val("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
